// File: rtl/alta_fifo_pkg.sv
// Shared constants and elaboration helpers for the alta_ram4k FIFO controller.
package alta_fifo_pkg;

  localparam int OBUF_DEPTH = 2;

  // RAM address width implied by each legal word width; 0 marks an illegal width.
  function automatic int addr_width_for(input int data_width);
    case (data_width)
      18, 16:  return 8;
      9, 8:    return 9;
      4:       return 10;
      2:       return 11;
      1:       return 12;
      default: return 0;
    endcase
  endfunction

  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/alta_fifo_outbuf.sv
// Two-entry capture/pop buffer that hides the RAM read latency; head register drives the output.
module alta_fifo_outbuf
  import alta_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  CapValid,
  input  logic [DATA_WIDTH-1:0] CapData,
  input  logic                  Pop,
  output logic [DATA_WIDTH-1:0] Data,
  output logic                  Valid,
  output logic [1:0]            Cnt
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pop_ok;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    pop_ok = Pop && (cnt_q != 2'd0);
    case (cnt_q)
      2'd0: begin
        if (CapValid) begin
          head_d = CapData;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (pop_ok && CapValid) begin
          head_d = CapData;
        end else if (pop_ok) begin
          cnt_d = 2'd0;
        end else if (CapValid) begin
          tail_d = CapData;
          cnt_d  = 2'd2;
        end
      end
      2'd2: begin
        // A capture into a full buffer is only possible alongside a pop.
        if (pop_ok) begin
          head_d = tail_q;
          if (CapValid) tail_d = CapData;
          else          cnt_d  = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge Clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
    if (!ResetN) cnt_q <= 2'd0;
    else         cnt_q <= cnt_d;
  end

  assign Data  = head_q;
  assign Valid = (cnt_q != 2'd0);
  assign Cnt   = cnt_q;

endmodule

// File: rtl/alta_ram4k_fifo.sv
// First-word-fall-through FIFO controller driving a simple-dual-port alta_ram4k (A write, B read).
// valid/ready: a word moves on a rising edge where valid and ready are both high; valid never waits on ready.
module alta_ram4k_fifo
  import alta_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 4
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [ADDR_WIDTH+1:0] Level,
  output logic                  AlmostFull,
  output logic [ADDR_WIDTH-1:0] RamAddrA,
  output logic [DATA_WIDTH-1:0] RamDataA,
  output logic                  RamWeA,
  output logic [ADDR_WIDTH-1:0] RamAddrB,
  output logic                  RamReB,
  input  logic [DATA_WIDTH-1:0] RamDataB
);

  localparam int LW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]         AF_CNT   = LW'(AF_LEVEL);
  localparam logic [2:0]            OBUF_MAX = 3'(OBUF_DEPTH);

  if (addr_width_for(DATA_WIDTH) != ADDR_WIDTH) begin : g_bad_geometry
    $error("alta_ram4k_fifo: ADDR_WIDTH does not match the RAM geometry for DATA_WIDTH");
  end

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [LW-1:0]         level_q, level_d;
  logic [1:0]            obuf_cnt;
  logic                  out_valid;
  logic                  in_ready, push, pop, issue;

  always_comb begin
    in_ready = ResetN && (ram_cnt_q != FULL_CNT);
    push     = InValid && in_ready;
    pop      = out_valid && OutReady;
    // Slots committed after this edge must stay within the output buffer.
    issue    = ResetN && (ram_cnt_q != '0) &&
               (({1'b0, obuf_cnt} + {2'b00, rd_pend_q}) < (OBUF_MAX + {2'b00, pop}));

    wptr_d    = push  ? wptr_q + PTR_ONE : wptr_q;
    rptr_d    = issue ? rptr_q + PTR_ONE : rptr_q;
    rd_pend_d = issue;

    ram_cnt_d = ram_cnt_q;
    if (push && !issue)      ram_cnt_d = ram_cnt_q + CNT_ONE;
    else if (issue && !push) ram_cnt_d = ram_cnt_q - CNT_ONE;

    // Issue and capture only move words between stages; only the two handshakes change the total.
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      level_q   <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      level_q   <= level_d;
    end
  end

  alta_fifo_outbuf #(.DATA_WIDTH(DATA_WIDTH)) u_outbuf (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .CapValid (rd_pend_q),
    .CapData  (RamDataB),
    .Pop      (pop),
    .Data     (OutData),
    .Valid    (out_valid),
    .Cnt      (obuf_cnt)
  );

  assign InReady    = in_ready;
  assign OutValid   = out_valid;
  assign RamWeA     = push;
  assign RamAddrA   = wptr_q;
  assign RamDataA   = InData;
  assign RamReB     = issue;
  assign RamAddrB   = rptr_q;
  assign Level      = level_q;
  assign AlmostFull = (level_q >= AF_CNT);

endmodule

// File: tb/tb_alta_ram4k_fifo.sv
// Bench for alta_ram4k_fifo: behavioural RAM, queue-based reference model, directed and random traffic.
module tb_alta_ram4k_fifo;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int AF    = 252;

  logic          clk = 1'b0;
  logic          ResetN = 1'b0;
  logic [DW-1:0] InData = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [DW-1:0] OutData;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [AW+1:0] Level;
  logic          AlmostFull;
  logic [AW-1:0] RamAddrA;
  logic [DW-1:0] RamDataA;
  logic          RamWeA;
  logic [AW-1:0] RamAddrB;
  logic          RamReB;
  logic [DW-1:0] RamDataB;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  int            m_lvl = 0;
  int            m_rc = 0;
  logic [AW-1:0] m_wc = '0;
  logic [AW-1:0] m_rdc = '0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_out = '0;

  always #5 clk = ~clk;

  alta_ram4k_fifo dut (
    .Clk        (clk),
    .ResetN     (ResetN),
    .InData     (InData),
    .InValid    (InValid),
    .InReady    (InReady),
    .OutData    (OutData),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .Level      (Level),
    .AlmostFull (AlmostFull),
    .RamAddrA   (RamAddrA),
    .RamDataA   (RamDataA),
    .RamWeA     (RamWeA),
    .RamAddrB   (RamAddrB),
    .RamReB     (RamReB),
    .RamDataB   (RamDataB)
  );

  // Simple-dual-port RAM with a one-cycle unregistered read.
  always @(posedge clk) begin
    if (RamWeA) mem[RamAddrA] <= RamDataA;
    if (RamReB) ram_out <= mem[RamAddrB];
  end
  assign RamDataB = ram_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: queue of accepted words, total words held, and words still in the RAM array.
  task automatic monitor();
    logic [DW-1:0] exp_word;
    forever begin
      @(negedge clk);
      if (!ResetN) begin
        chk("in_ready_rst", {31'd0, InReady}, 32'd0);
        exp_q.delete();
        m_lvl = 0;
        m_rc  = 0;
        m_wc  = '0;
        m_rdc = '0;
      end else begin
        chk("level", {22'd0, Level}, m_lvl);
        chk("almost_full", {31'd0, AlmostFull}, {31'd0, (m_lvl >= AF)});
        chk("in_ready", {31'd0, InReady}, {31'd0, (m_rc < DEPTH)});
        chk("we_a", {31'd0, RamWeA}, {31'd0, (InValid && (m_rc < DEPTH))});
        if (m_lvl == 0) chk("out_valid_empty", {31'd0, OutValid}, 32'd0);
        if (RamWeA) begin
          chk("addr_a", {24'd0, RamAddrA}, {24'd0, m_wc});
          chk("data_a", {16'd0, RamDataA}, {16'd0, InData});
        end
        if (RamReB) begin
          chk("re_b_nonempty", {31'd0, (m_rc > 0)}, 32'd1);
          chk("addr_b", {24'd0, RamAddrB}, {24'd0, m_rdc});
        end
        if (OutValid && OutReady) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_empty: got %0h expected no word at %0t", OutData, $time);
          end else begin
            exp_word = exp_q.pop_front();
            chk("out_data", {16'd0, OutData}, {16'd0, exp_word});
          end
          m_lvl--;
        end
        if (InValid && InReady) begin
          exp_q.push_back(InData);
          m_lvl++;
          m_rc++;
          m_wc++;
        end
        if (RamReB) begin
          m_rc--;
          m_rdc++;
        end
      end
    end
  endtask

  task automatic drain();
    InValid  = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 700 && (Level != 0 || OutValid); i++) tick();
    chk("drain_level", {22'd0, Level}, 32'd0);
    OutReady = 1'b0;
    tick();
  endtask

  initial begin
    int pops;
    int pushed;
    int acc;
    fork
      monitor();
    join_none

    // Reset state and single-word latency.
    ResetN = 1'b0;
    repeat (3) tick();
    ResetN = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, OutValid}, 32'd0);
    chk("rst_level", {22'd0, Level}, 32'd0);
    chk("rst_almost_full", {31'd0, AlmostFull}, 32'd0);
    chk("rst_re_b", {31'd0, RamReB}, 32'd0);
    chk("rst_in_ready", {31'd0, InReady}, 32'd1);
    InValid = 1'b1;
    InData  = 16'h1234;
    #1;
    chk("lat_we_a", {31'd0, RamWeA}, 32'd1);
    chk("lat_addr_a", {24'd0, RamAddrA}, 32'd0);
    tick();
    InValid = 1'b0;
    #1;
    chk("lat_re_b", {31'd0, RamReB}, 32'd1);
    chk("lat_addr_b", {24'd0, RamAddrB}, 32'd0);
    chk("lat_valid_e0", {31'd0, OutValid}, 32'd0);
    tick();
    chk("lat_valid_e1", {31'd0, OutValid}, 32'd0);
    tick();
    chk("lat_valid_e2", {31'd0, OutValid}, 32'd1);
    chk("lat_data", {16'd0, OutData}, 32'h1234);
    chk("lat_level", {22'd0, Level}, 32'd1);
    drain();

    // Fill with the consumer stalled.
    acc = 0;
    InValid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      InData = 16'($urandom);
      #1;
      if (InReady) acc++;
      tick();
    end
    chk("fill_accepted", acc, 32'd258);
    chk("fill_level", {22'd0, Level}, 32'd258);
    chk("fill_in_ready", {31'd0, InReady}, 32'd0);
    chk("fill_almost_full", {31'd0, AlmostFull}, 32'd1);

    // Single pop at full with a push waiting.
    InData   = 16'hA5A5;
    OutReady = 1'b1;
    #1;
    chk("full_in_ready_pop", {31'd0, InReady}, 32'd0);
    tick();
    OutReady = 1'b0;
    #1;
    chk("full_level_after_pop", {22'd0, Level}, 32'd257);
    chk("full_in_ready_after", {31'd0, InReady}, 32'd1);
    tick();
    chk("full_level_refill", {22'd0, Level}, 32'd258);
    chk("full_in_ready_refill", {31'd0, InReady}, 32'd0);
    drain();

    // Continuous streaming: after the fill, one pop every cycle.
    pops = 0;
    InValid  = 1'b1;
    OutReady = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      InData = 16'(c);
      @(negedge clk);
      if (OutValid && OutReady) pops++;
      tick();
    end
    chk("stream_pops", pops, 32'd997);
    drain();

    // Random traffic.
    pushed = 0;
    for (int cyc = 0; cyc < 60000 && pushed < 10000; cyc++) begin
      InValid  = 1'($urandom_range(0, 1));
      OutReady = 1'($urandom_range(0, 1));
      InData   = 16'($urandom);
      @(negedge clk);
      if (InValid && InReady) pushed++;
      tick();
    end
    chk("rand_pushed", pushed, 32'd10000);
    drain();

    // Reset mid-operation discards contents.
    InValid = 1'b1;
    for (int i = 0; i < 37; i++) begin
      InData = 16'($urandom);
      tick();
    end
    InValid = 1'b0;
    #1;
    chk("pre_rst_level", {22'd0, Level}, 32'd37);
    ResetN = 1'b0;
    tick();
    ResetN = 1'b1;
    #1;
    chk("post_rst_valid", {31'd0, OutValid}, 32'd0);
    chk("post_rst_level", {22'd0, Level}, 32'd0);
    InValid = 1'b1;
    InData  = 16'hBEEF;
    tick();
    InValid = 1'b0;
    for (int i = 0; i < 10 && !OutValid; i++) tick();
    chk("post_rst_first_valid", {31'd0, OutValid}, 32'd1);
    chk("post_rst_first_data", {16'd0, OutData}, 32'hBEEF);
    drain();

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
